// File: rtl/flopr_pkg.sv
// flopr_pkg: shared width default for the two-phase register slice
package flopr_pkg;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/flopr_if.sv
// flopr_if: data-in / state-out bundle of a two-phase register
interface flopr_if
  import flopr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  modport master (output d, input q);
  modport slave (input d, output q);
endinterface

// File: rtl/flopr_latchr.sv
// latchr: level-sensitive latch with asynchronous active-high clear
module latchr
  import flopr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // clear dominates; otherwise follow d while enabled, hold when not
  always_latch
    if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/flopr.sv
// flopr: two-phase master/slave register, master open on ph2, slave open on ph1
module flopr
  import flopr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic    ph1,
  input logic    ph2,
  input logic    reset,
  flopr_if.slave bus
);
  logic [WIDTH-1:0] m;
  latchr #(.WIDTH(WIDTH)) master (.en(ph2), .clr(reset), .d(bus.d), .q(m));
  latchr #(.WIDTH(WIDTH)) slave (.en(ph1), .clr(reset), .d(m), .q(bus.q));
endmodule

// File: tb/tb_flopr.sv
// tb_flopr: directed and random checks of flopr against an edge-level flop model
module tb_flopr;
  logic ph1 = 1'b0;
  logic ph2 = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [7:0] cap8 = '0, mq8 = '0;
  logic [1:0] cap2 = '0, mq2 = '0;
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b10, 2'b00};

  flopr_if #(.WIDTH(8)) b8 ();
  flopr_if #(.WIDTH(2)) b2 ();

  flopr #(.WIDTH(8)) u8 (.ph1(ph1), .ph2(ph2), .reset(reset), .bus(b8.slave));
  flopr #(.WIDTH(2)) u2 (.ph1(ph1), .ph2(ph2), .reset(reset), .bus(b2.slave));

  // non-overlapping phases, period 40: ph2 high 5..15, ph1 high 20..30
  always begin
    #5 ph2 = 1'b1;
    #10 ph2 = 1'b0;
    #5 ph1 = 1'b1;
    #10 ph1 = 1'b0;
    #10;
  end

  // reference: d sampled at ph2 fall, shown at ph1 rise, cleared by reset
  always @(negedge ph2) if (!reset) begin cap8 = b8.d; cap2 = b2.d; end
  always @(posedge ph1) if (!reset) begin mq8 = cap8; mq2 = cap2; end
  always @(posedge reset) begin cap8 = '0; cap2 = '0; mq8 = '0; mq2 = '0; end

  initial begin
    #20000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_q8"}, 64'(b8.q), 64'(mq8));
    chk({tag, "_q2"}, 64'(b2.q), 64'(mq2));
  endtask

  initial begin
    reset = 1'b1;
    b8.d = 8'hFF;
    b2.d = 2'b11;
    #1;
    chk("reset_imm_q2", 64'(b2.q), 64'h0);
    chk("reset_imm_q8", 64'(b8.q), 64'h0);
    repeat (3) begin
      @(posedge ph1) #2;
      chk("reset_hold_q2", 64'(b2.q), 64'h0);
      chk("reset_hold_q8", 64'(b8.q), 64'h0);
    end
    @(negedge ph1) #2 reset = 1'b0;
    @(posedge ph2) #2 b8.d = 8'hA5;
    @(negedge ph2) #2 b8.d = 8'h3C;
    @(posedge ph1) #2 chk("cap_a5", 64'(b8.q), 64'hA5);
    @(posedge ph2) #3 chk("cap_hold_a5", 64'(b8.q), 64'hA5);
    @(posedge ph1) #2 chk("cap_3c", 64'(b8.q), 64'h3C);
    @(posedge ph2) #2 b8.d = 8'h00;
    #5 b8.d = 8'hFF;
    @(negedge ph2) #2 b8.d = 8'h11;
    @(posedge ph1) #2 chk("late_ff", 64'(b8.q), 64'hFF);
    @(posedge ph1) #2 chk("late_11", 64'(b8.q), 64'h11);
    @(posedge ph2) #2 b8.d = 8'h5A;
    @(posedge ph1) #2 chk("mid_5a", 64'(b8.q), 64'h5A);
    #1 reset = 1'b1;
    #1 chk("mid_reset_q8", 64'(b8.q), 64'h0);
    #1 reset = 1'b0;
    b8.d = 8'h81;
    #1 chk("mid_release_q8", 64'(b8.q), 64'h0);
    @(posedge ph1) #2 chk("mid_81", 64'(b8.q), 64'h81);
    @(posedge ph2) #1 reset = 1'b1;
    b2.d = 2'b10;
    #1 chk("ph2rel_reset_q2", 64'(b2.q), 64'h0);
    #2 reset = 1'b0;
    #1 chk("ph2rel_after_q2", 64'(b2.q), 64'h0);
    @(posedge ph1) #2 chk("ph2rel_10", 64'(b2.q), 64'h2);
    b2.d = 2'b01;
    @(posedge ph1) #1 reset = 1'b1;
    #2 reset = 1'b0;
    #1 chk("ph1rel_q2", 64'(b2.q), 64'h0);
    @(posedge ph2) #2 chk("ph1rel_hold_q2", 64'(b2.q), 64'h0);
    @(posedge ph1) #2 chk("ph1rel_01", 64'(b2.q), 64'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge ph2) #2 b2.d = seq[i];
      @(posedge ph1) #2 chk("seq_q2", 64'(b2.q), 64'(seq[i]));
    end
    chk_model("directed_end");
    repeat (40) begin
      @(posedge ph2) #2;
      b8.d = 8'($urandom);
      b2.d = 2'($urandom);
      #5;
      b8.d = 8'($urandom);
      b2.d = 2'($urandom);
      @(negedge ph2) #2;
      b8.d = 8'($urandom);
      b2.d = 2'($urandom);
      @(posedge ph1) #2 chk_model("rnd_ph1");
      if ($urandom_range(7) == 0) begin
        #1 reset = 1'b1;
        #1 chk_model("rnd_reset");
        #1 reset = 1'b0;
      end
      @(posedge ph2) #1 chk_model("rnd_ph2");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
